lab5_tap_feeder: RTL and testbench

- Streaming front end for the 3-tap weighted-sum datapath (k1=-0.5, k2=0.625, k3=-0.5, 1.11 fixed point).
- Accepts one signed 10-bit sample per handshake and keeps a 3-deep history.
- Presents the newest three samples as x1/x2/x3, registered, with a valid/ready handshake toward the combinational datapath and its consumer.
- Handles start-up priming, backpressure and flush, so the datapath only ever sees a coherent tap set.

---
 rtl/lab5_tap_feeder_if.sv | 26 ++
 rtl/lab5_tap_feeder.sv | 79 +++++++
 tb/tb_lab5_tap_feeder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lab5_tap_feeder_if.sv
// Handshake bundle between the sample source, the tap feeder and the
// downstream weighted-sum consumer. The feeder itself sits on the slave modport.
interface lab5_tap_feeder_if #(
    parameter int DATA_W = 10
);
    logic signed [DATA_W-1:0] din;
    logic                     din_valid;
    logic                     din_ready;
    logic                     flush;
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] x3;
    logic                     taps_valid;
    logic                     out_ready;
    logic [1:0]               fill;

    modport master (
        output din, din_valid, flush, out_ready,
        input  din_ready, x1, x2, x3, taps_valid, fill
    );

    modport slave (
        input  din, din_valid, flush, out_ready,
        output din_ready, x1, x2, x3, taps_valid, fill
    );
endinterface

// File: rtl/lab5_tap_feeder.sv
// Three-deep sample history feeding a 3-tap weighted-sum datapath. The tap set
// is registered and handed over with a one-deep valid/ready output stage.
module lab5_tap_feeder #(
    parameter int DATA_W     = 10,
    parameter bit PRIME_ZERO = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    lab5_tap_feeder_if.slave        bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        RUN   = 2'd3
    } state_e;

    state_e                   state_q;
    state_e                   state_d;
    logic signed [DATA_W-1:0] x1_q;
    logic signed [DATA_W-1:0] x2_q;
    logic signed [DATA_W-1:0] x3_q;
    logic                     taps_valid_q;
    logic                     din_ready;
    logic                     accept;

    // A new sample may only enter when the output stage is empty or draining now.
    assign din_ready = reset_n & ~bus.flush & (~taps_valid_q | bus.out_ready);
    assign accept    = bus.din_valid & din_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   state_d = FILL1;
            FILL1:   state_d = FILL2;
            FILL2:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            x1_q         <= '0;
            x2_q         <= '0;
            x3_q         <= '0;
            taps_valid_q <= 1'b0;
        end else if (bus.flush) begin
            // Flush wins over a concurrent accept; din_ready is low so nothing is lost.
            state_q      <= EMPTY;
            x1_q         <= '0;
            x2_q         <= '0;
            x3_q         <= '0;
            taps_valid_q <= 1'b0;
        end else if (accept) begin
            state_q <= state_d;
            x1_q    <= bus.din;
            x2_q    <= x1_q;
            x3_q    <= x2_q;
            if (state_d == RUN || PRIME_ZERO) begin
                taps_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                taps_valid_q <= 1'b0;
            end
        end else if (bus.out_ready) begin
            taps_valid_q <= 1'b0;
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.x1         = x1_q;
    assign bus.x2         = x2_q;
    assign bus.x3         = x3_q;
    assign bus.taps_valid = taps_valid_q;
    assign bus.fill       = state_q;

endmodule

// File: tb/tb_lab5_tap_feeder.sv
// Directed plus randomized check of both priming modes against a history-queue model.
module tb_lab5_tap_feeder;

    localparam int DW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    lab5_tap_feeder_if #(.DATA_W(DW)) if0 ();
    lab5_tap_feeder_if #(.DATA_W(DW)) if1 ();

    lab5_tap_feeder #(.DATA_W(DW), .PRIME_ZERO(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0)
    );
    lab5_tap_feeder #(.DATA_W(DW), .PRIME_ZERO(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: history as plain arrays, newest at index 0.
    logic signed [DW-1:0] m_hist [2][3];
    int                   m_cnt  [2];
    logic                 m_tv   [2];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready(input int i, input logic f, input logic ordy);
        return reset_n && !f && (!m_tv[i] || ordy);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) m_hist[i][k] = '0;
            m_cnt[i] = 0;
            m_tv[i]  = 1'b0;
        end
    endtask

    task automatic model_clock(input int i, input logic signed [DW-1:0] d, input logic v,
                               input logic f, input logic ordy);
        logic acc;
        acc = v && model_ready(i, f, ordy);
        if (f) begin
            for (int k = 0; k < 3; k++) m_hist[i][k] = '0;
            m_cnt[i] = 0;
            m_tv[i]  = 1'b0;
        end else if (acc) begin
            m_hist[i][2] = m_hist[i][1];
            m_hist[i][1] = m_hist[i][0];
            m_hist[i][0] = d;
            m_cnt[i]     = (m_cnt[i] >= 3) ? 3 : m_cnt[i] + 1;
            if (m_cnt[i] == 3 || i == 1) m_tv[i] = 1'b1;
            else if (ordy) m_tv[i] = 1'b0;
        end else if (ordy) begin
            m_tv[i] = 1'b0;
        end
    endtask

    task automatic check_outs(input string ph);
        check({ph, " pz0 x1"},   16'(if0.x1),         16'(m_hist[0][0]));
        check({ph, " pz0 x2"},   16'(if0.x2),         16'(m_hist[0][1]));
        check({ph, " pz0 x3"},   16'(if0.x3),         16'(m_hist[0][2]));
        check({ph, " pz0 tv"},   16'(if0.taps_valid), 16'(m_tv[0]));
        check({ph, " pz0 fill"}, 16'(if0.fill),       16'(m_cnt[0]));
        check({ph, " pz1 x1"},   16'(if1.x1),         16'(m_hist[1][0]));
        check({ph, " pz1 x2"},   16'(if1.x2),         16'(m_hist[1][1]));
        check({ph, " pz1 x3"},   16'(if1.x3),         16'(m_hist[1][2]));
        check({ph, " pz1 tv"},   16'(if1.taps_valid), 16'(m_tv[1]));
        check({ph, " pz1 fill"}, 16'(if1.fill),       16'(m_cnt[1]));
    endtask

    // One clock: drive at negedge, check ready before the edge, outputs after it.
    task automatic step(input string ph, input logic signed [DW-1:0] d, input logic v,
                        input logic f, input logic ordy);
        if0.din = d; if0.din_valid = v; if0.flush = f; if0.out_ready = ordy;
        if1.din = d; if1.din_valid = v; if1.flush = f; if1.out_ready = ordy;
        #1;
        check({ph, " pz0 din_ready"}, 16'(if0.din_ready), 16'(model_ready(0, f, ordy)));
        check({ph, " pz1 din_ready"}, 16'(if1.din_ready), 16'(model_ready(1, f, ordy)));
        @(posedge clk);
        model_clock(0, d, v, f, ordy);
        model_clock(1, d, v, f, ordy);
        #1;
        check_outs(ph);
        $display("[%0t] %s din=%h v=%b fl=%b ordy=%b | pz0 x=%h,%h,%h tv=%b fill=%0d | pz1 x=%h,%h,%h tv=%b fill=%0d",
                 $time, ph, d, v, f, ordy, if0.x1, if0.x2, if0.x3, if0.taps_valid, if0.fill,
                 if1.x1, if1.x2, if1.x3, if1.taps_valid, if1.fill);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        if0.din = '0; if0.din_valid = 1'b0; if0.flush = 1'b0; if0.out_ready = 1'b0;
        if1.din = '0; if1.din_valid = 1'b0; if1.flush = 1'b0; if1.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("reset");
        check("reset pz0 din_ready", 16'(if0.din_ready), 16'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Priming and streaming
        step("prime", 10'h001, 1'b1, 1'b0, 1'b1);
        step("prime", 10'h002, 1'b1, 1'b0, 1'b1);
        step("prime", 10'h003, 1'b1, 1'b0, 1'b1);
        check("prime tap x1", 16'(if0.x1), 16'h0003);
        check("prime tap x3", 16'(if0.x3), 16'h0001);
        step("stream", 10'h3FF, 1'b1, 1'b0, 1'b1);
        step("stream", 10'h200, 1'b1, 1'b0, 1'b1);
        check("stream pz0 x2", 16'(if0.x2), 16'hFFFF);

        // Backpressure then release
        for (int k = 0; k < 4; k++) step("bp", 10'h010, 1'b1, 1'b0, 1'b0);
        step("bp_rel", 10'h010, 1'b1, 1'b0, 1'b1);
        check("bp_rel pz0 x1", 16'(if0.x1), 16'h0010);

        // Flush with a concurrent sample, then refill
        step("flush", 10'h055, 1'b1, 1'b1, 1'b1);
        step("refill", 10'h100, 1'b1, 1'b0, 1'b1);
        check("refill pz1 x1", 16'(if1.x1), 16'h0100);
        step("refill", 10'h101, 1'b1, 1'b0, 1'b1);
        step("refill", 10'h102, 1'b1, 1'b0, 1'b0);
        step("hold", 10'h103, 1'b1, 1'b0, 1'b0);

        // Async reset between edges while taps are valid
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_rst");
        check("async_rst pz0 din_ready", 16'(if0.din_ready), 16'h0);
        check("async_rst pz1 din_ready", 16'(if1.din_ready), 16'h0);
        @(negedge clk);
        step("in_rst", 10'h111, 1'b1, 1'b0, 1'b1);
        reset_n = 1'b1;
        step("pz1_first", 10'h100, 1'b1, 1'b0, 1'b1);
        check("pz1_first x1", 16'(if1.x1), 16'h0100);
        check("pz1_first tv", 16'(if1.taps_valid), 16'h0001);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic signed [DW-1:0] d;
            d = DW'($urandom);
            step("rand", d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
